// File: rtl/bit_serial_alu.sv
// ---------------------------------------------------------------------------
// bit_serial_alu
//
// Bit-serial ALU. One request (a, b, op) is accepted with a valid/ready
// handshake. The operands are then processed one bit per clock, LSB first,
// through a single 1-bit slice, and the result is held with its status
// flags until the consumer takes it.
//
// op encoding: 00 AND, 01 ADD, 10 SUB (a-b), 11 CMP (flags only, y = 0).
// SUB/CMP are computed as a + ~b + 1: b is inverted at acceptance and the
// running carry is preset to 1, so the final carry is the "not borrow".
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  block can accept a request
//   a, b       in   WIDTH-bit unsigned operands
//   op         in   2-bit operation select
//   out_valid  out  result present
//   out_ready  in   consumer takes the result
//   y          out  WIDTH-bit result
//   carry      out  final slice carry (ADD carry-out, SUB/CMP not-borrow)
//   eq         out  raw result is zero
//   lt         out  a < b (SUB/CMP only)
//
// Configuration macro
//   BSALU_BACK2BACK_EN  when defined, in_ready is also high in DONE while
//                       out_ready is high, so a new request is accepted on
//                       the same edge that the current result is consumed.
//                       When undefined, requests are accepted only in IDLE.
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request, in_ready = 1
// SHIFT  | processing one operand bit per cycle, WIDTH cycles
// DONE   | result and flags held, out_valid = 1 until out_ready
// ---------------------------------------------------------------------------
module bit_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             eq,
  output logic             lt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic             accept;
  logic             result_taken;

  // 1-bit slice signals
  logic             slice_a;
  logic             slice_b;
  logic             slice_sum;
  logic             slice_cout;
  logic             slice_bit;
  logic             slice_cy;
  logic [WIDTH-1:0] res_shifted;
  logic             is_sub_q;
  logic             is_sub_in;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
`ifdef BSALU_BACK2BACK_EN
  // Accepting in DONE is only safe when the held result leaves on this same
  // edge, hence the dependency on out_ready.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
`else
  assign in_ready = (state_q == S_IDLE);
`endif

  assign out_valid    = (state_q == S_DONE);
  assign accept       = in_valid && in_ready;
  assign result_taken = out_valid && out_ready;

  assign is_sub_in = op[1];
  assign is_sub_q  = op_q[1];

  // -------------------------------------------------------------------------
  // Bit slice: AND, or a full adder shared by ADD/SUB/CMP
  // -------------------------------------------------------------------------
  always_comb begin
    slice_a    = a_q[0];
    slice_b    = b_q[0];
    slice_sum  = slice_a ^ slice_b ^ cy_q;
    slice_cout = (slice_a & slice_b) | (cy_q & (slice_a ^ slice_b));
    if (op_q == OP_AND) begin
      slice_bit = slice_a & slice_b;
      slice_cy  = 1'b0;
    end else begin
      slice_bit = slice_sum;
      slice_cy  = slice_cout;
    end
    // The new bit enters at the MSB; after WIDTH shifts the first (LSB)
    // bit has reached position 0.
    res_shifted = {slice_bit, res_q[WIDTH-1:1]};
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    res_d   = res_q;
    y_d     = y_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    lt_d    = lt_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end

      S_SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        cy_d  = slice_cy;
        res_d = res_shifted;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          y_d     = (op_q == OP_CMP) ? '0 : res_shifted;
          carry_d = slice_cy;
          eq_d    = (res_shifted == '0);
          lt_d    = is_sub_q & ~slice_cy;
        end
      end

      S_DONE: begin
        if (result_taken) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acceptance overrides the state decisions above. Outside IDLE this can
    // only happen in DONE with back-to-back enabled, where it coincides with
    // the result being taken.
    if (accept) begin
      state_d = S_SHIFT;
      a_d     = a;
      b_d     = is_sub_in ? ~b : b;
      op_d    = op;
      cnt_d   = '0;
      cy_d    = is_sub_in;
      res_d   = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign y     = y_q;
  assign carry = carry_q;
  assign eq    = eq_q;
  assign lt    = lt_q;

endmodule

// File: doc/bit_serial_alu.md
BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; the legal range is WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a request is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have ports a and b, inputs, WIDTH bits each: unsigned operands.
REQ-007 The block SHALL have port op, input, 2 bits: 00 AND, 01 ADD, 10 SUB (a-b), 11 CMP.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is present.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port y, output, WIDTH bits: the result.
REQ-011 The block SHALL have ports carry, eq and lt, outputs, 1 bit each: status flags.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; on in_valid & in_ready, a, b and op SHALL be latched, the bit counter cleared, and the FSM SHALL go to SHIFT.
REQ-014 The carry flop SHALL load 0 for AND/ADD and 1 for SUB/CMP at acceptance; for SUB/CMP, b SHALL be bitwise inverted at acceptance.
REQ-015 In SHIFT, one bit per cycle, LSB first, SHALL pass through a 1-bit slice (AND: a&b; ADD/SUB/CMP: full-adder sum/carry); the result bit SHALL shift into the MSB of the result register.
REQ-016 After exactly WIDTH SHIFT cycles the FSM SHALL enter DONE; out_valid SHALL rise on the WIDTH-th rising edge after the acceptance edge.
REQ-017 Flags SHALL be: carry = final slice carry (ADD carry-out, SUB/CMP not-borrow, AND 0); eq = (raw result == 0); lt = ~carry for SUB/CMP, 0 otherwise.
REQ-018 For op CMP, y SHALL be 0; only the flags are meaningful.
REQ-019 In DONE, y, carry, eq, lt and out_valid SHALL hold stable until out_valid & out_ready, after which the FSM SHALL go to IDLE and out_valid SHALL fall.
REQ-020 Changes on a, b and op after acceptance SHALL be ignored; in_valid in SHIFT/DONE SHALL be ignored (in_ready 0), except as stated in REQ-024.
REQ-021 out_ready outside DONE SHALL have no effect; y and the flags SHALL retain the previous result until a new result is presented.

Reset
REQ-022 On rst_n low, the block SHALL enter IDLE immediately, with in_ready=1, out_valid=0, y=0 and carry=eq=lt=0, and the counter and operand registers cleared.
REQ-023 A reset asserted mid-SHIFT or in DONE SHALL abort the operation with no result emitted; the first request after reset release SHALL complete correctly.

Configuration
REQ-024 Macro BSALU_BACK2BACK_EN: when defined, in_ready SHALL also be 1 in DONE while out_ready is 1, so that a new request is accepted on the same edge that the result is consumed (FSM DONE->SHIFT, sustained throughput of one op per WIDTH+1 cycles incl. the DONE handshake cycle); when undefined, in_ready SHALL be 1 only in IDLE, forcing at least one IDLE cycle between operations.

Verification (WIDTH=8)
REQ-025 AND a=0xF0, b=0x3C -> out_valid 8 cycles after accept; y=0x30, carry=0, eq=0, lt=0.
REQ-026 ADD a=0xFF, b=0x01 -> y=0x00, carry=1, eq=1, lt=0.
REQ-027 SUB a=0x05, b=0x07 -> y=0xFE, carry=0, lt=1, eq=0; CMP a=0x42, b=0x42 -> y=0x00, eq=1, lt=0, carry=1.
REQ-028 Backpressure: hold out_ready=0 for 5 cycles in DONE -> y and the flags stay stable, in_ready=0, and a second in_valid is not accepted; release -> handshake on one edge, then IDLE.
REQ-029 Assert rst_n low during the 4th SHIFT cycle -> all outputs zero immediately, and no out_valid; then ADD 0x10+0x20 -> y=0x30.
REQ-030 Two queued requests with out_ready=1: with BSALU_BACK2BACK_EN the second is accepted on the first result's handshake edge; without it, exactly one IDLE cycle separates the first result's handshake edge from the second request's acceptance edge.
